// File: rtl/fpu_pkg.sv
// Shared widths, GRS bit positions, rounding-mode encoding and IEEE-754 constants
// for the single-precision add/sub datapath.
package fpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MENT_WIDTH = 23;
  localparam int EXPO_WIDTH = 8;
  localparam int GRS_WIDTH  = 3;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } round_mode_t;

  localparam logic [EXPO_WIDTH-1:0] EXP_ALL_ONES   = '1;
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX_FINITE = EXP_ALL_ONES - EXPO_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] QNAN_DEFAULT   = 32'h7FC0_0000;

  function automatic logic [DATA_WIDTH-1:0] pack_fp(
    input logic                  sign,
    input logic [EXPO_WIDTH-1:0] expo,
    input logic [MENT_WIDTH-1:0] frac
  );
    return {sign, expo, frac};
  endfunction

endpackage

// File: rtl/addition_round_decide.sv
// Combinational rounding decision: given sign, fraction LSB, GRS bits and the
// rounding mode, decide whether to increment the fraction and whether the result is inexact.
module addition_round_decide
  import fpu_pkg::*;
(
  input  logic                 sign,
  input  logic                 lsb,
  input  logic [GRS_WIDTH-1:0] grs,
  input  round_mode_t          mode,
  output logic                 inc,
  output logic                 inexact
);

  always_comb begin
    inexact = |grs;
    inc     = 1'b0;
    unique case (mode)
      RNE:     inc = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | lsb);
      RTZ:     inc = 1'b0;
      RUP:     inc = ~sign & (|grs);
      RDN:     inc = sign & (|grs);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/addition_round_stage.sv
// Stage 5 of the FP add/sub datapath: round, renormalize on carry-out, saturate on
// overflow and pack the IEEE-754 word. Optional FPU_ROUND_MODE_EN adds round_mode_in.
module addition_round_stage
  import fpu_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  input  logic [MENT_WIDTH-1:0] mentissa_in,
  input  logic [GRS_WIDTH-1:0]  grs_in,
  input  logic                  zero_in,
`ifdef FPU_ROUND_MODE_EN
  input  logic [1:0]            round_mode_in,
`endif
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_round_out,
  output logic                  overflow_out,
  output logic                  inexact_out
);

  // Handshake: a word moves on valid & ready at a rising edge. A stage may load
  // when it is empty or the stage after it is draining this cycle; ready_out is
  // derived only from stage valids and ready_in, never from input data.
  logic adv1;
  logic adv2;

  logic                  s1_valid;
  logic                  s1_sign;
  logic [EXPO_WIDTH-1:0] s1_exp;
  logic [MENT_WIDTH:0]   s1_frac;
  logic                  s1_pass;
  logic                  s1_inexact;
  logic                  s1_sat;

  assign adv2      = ~valid_out | ready_in;
  assign adv1      = ~s1_valid | adv2;
  assign ready_out = adv1;

  // ---------------- stage 1: round decision ----------------
  round_mode_t           mode;
  logic                  special;
  logic                  pass;
  logic                  dec_inc;
  logic                  dec_inexact;
  logic                  inc;
  logic                  inexact_next;
  logic [MENT_WIDTH:0]   frac_next;
  logic [EXPO_WIDTH-1:0] exp_next;
  logic                  sat_next;

`ifdef FPU_ROUND_MODE_EN
  assign mode = round_mode_t'(round_mode_in);
`else
  assign mode = RNE;
`endif

  assign special = (exponent_in == EXP_ALL_ONES);
  assign pass    = special | zero_in;

  addition_round_decide u_decide (
    .sign    (sign_in),
    .lsb     (mentissa_in[0]),
    .grs     (grs_in),
    .mode    (mode),
    .inc     (dec_inc),
    .inexact (dec_inexact)
  );

  assign inc          = dec_inc & ~pass;
  assign inexact_next = dec_inexact & ~pass;
  assign exp_next     = zero_in ? '0 : exponent_in;
  assign frac_next    = zero_in ? '0 : ({1'b0, mentissa_in} + (MENT_WIDTH + 1)'(inc));

`ifdef FPU_ROUND_MODE_EN
  // A max-finite magnitude with discarded bits overflows even when the mode
  // refuses to increment; stage 2 then clamps to max finite instead of infinity.
  assign sat_next = ~pass & ~inc & (mode != RNE) & (|grs_in) &
                    (exponent_in == EXP_MAX_FINITE) & (&mentissa_in);
`else
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_pass    <= 1'b0;
      s1_inexact <= 1'b0;
      s1_sat     <= 1'b0;
    end else if (adv1) begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_sign    <= sign_in;
        s1_exp     <= exp_next;
        s1_frac    <= frac_next;
        s1_pass    <= pass;
        s1_inexact <= inexact_next;
        s1_sat     <= sat_next;
      end
    end
  end

  // ---------------- stage 2: renormalize and pack ----------------
  logic                  carry;
  logic [EXPO_WIDTH-1:0] exp_r;
  logic [MENT_WIDTH-1:0] frac_r;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  ovf_next;

  assign carry  = s1_frac[MENT_WIDTH];
  assign exp_r  = s1_exp + EXPO_WIDTH'(carry);
  assign frac_r = carry ? '0 : s1_frac[MENT_WIDTH-1:0];

  always_comb begin
    word_next = pack_fp(s1_sign, exp_r, frac_r);
    ovf_next  = 1'b0;
    if (!s1_pass && exp_r == EXP_ALL_ONES) begin
      word_next = pack_fp(s1_sign, EXP_ALL_ONES, '0);
      ovf_next  = 1'b1;
    end else if (s1_sat) begin
      word_next = pack_fp(s1_sign, EXP_MAX_FINITE, '1);
      ovf_next  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out          <= 1'b0;
      floating_round_out <= '0;
      overflow_out       <= 1'b0;
      inexact_out        <= 1'b0;
    end else if (adv2) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        floating_round_out <= word_next;
        overflow_out       <= ovf_next;
        inexact_out        <= s1_inexact;
      end
    end
  end

endmodule

// File: tb/tb_addition_round_stage.sv
// Self-checking bench for addition_round_stage: directed cases, backpressure,
// mid-flight reset and randomized words scored against a magnitude-level model.
module tb_addition_round_stage;
  import fpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic        sign_in;
  logic [7:0]  exponent_in;
  logic [22:0] mentissa_in;
  logic [2:0]  grs_in;
  logic        zero_in;
  logic [1:0]  round_mode_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] floating_round_out;
  logic        overflow_out;
  logic        inexact_out;

  addition_round_stage dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .valid_in           (valid_in),
    .ready_out          (ready_out),
    .sign_in            (sign_in),
    .exponent_in        (exponent_in),
    .mentissa_in        (mentissa_in),
    .grs_in             (grs_in),
    .zero_in            (zero_in),
`ifdef FPU_ROUND_MODE_EN
    .round_mode_in      (round_mode_in),
`endif
    .valid_out          (valid_out),
    .ready_in           (ready_in),
    .floating_round_out (floating_round_out),
    .overflow_out       (overflow_out),
    .inexact_out        (inexact_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  string       cur_tag = "init";
  logic [33:0] exp_q[$];
  logic [34:0] held;
  logic        stalled_prev = 1'b0;
  logic        accepted = 1'b0;
  logic        rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, tag, obs, expv);
    end
  endtask

  // Reference: rounding increments the {exp,frac} magnitude as one integer, so a
  // fraction carry walks into the exponent by itself; reaching exponent 255 is overflow.
  function automatic logic [33:0] ref_model(input logic s, input logic [7:0] e,
                                            input logic [22:0] f, input logic [2:0] g,
                                            input logic z, input logic [1:0] m);
    logic [30:0] mag;
    int unsigned r;
    logic        up;
    logic        ovf;
    if (z) return {2'b00, s, 31'd0};
    if (e == 8'hFF) return {2'b00, s, e, f};
    mag = {e, f};
    r   = 32'(g);
    case (m)
      2'd0:    up = (r > 4) || (r == 4 && mag[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && (r != 0);
      default: up = s && (r != 0);
    endcase
    ovf = 1'b0;
    if (m != 2'd0 && !up && r != 0 && mag == 31'h7F7F_FFFF) ovf = 1'b1;
    mag = mag + 31'(up);
    if (mag[30:23] == 8'hFF) begin
      ovf = 1'b1;
      mag = 31'h7F80_0000;
    end
    return {ovf, (r != 0), s, mag};
  endfunction

  // One clock: called just after a falling edge with inputs driven, returns at the next falling edge.
  task automatic cycle();
    logic [34:0] now_o;
    logic [33:0] e;
    if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
    #1;
    now_o = {valid_out, overflow_out, inexact_out, floating_round_out};
    if (stalled_prev) chk("hold_stable", 64'(now_o), 64'(held));
    if (valid_out && ready_in) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'(valid_out), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("word", 64'(now_o[33:0]), 64'(e));
      end
    end
    held         = now_o;
    stalled_prev = valid_out && !ready_in;
    accepted     = valid_in && ready_out;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] f,
                      input logic [2:0] g, input logic z, input logic [1:0] m,
                      input logic [33:0] expected);
    sign_in       = s;
    exponent_in   = e;
    mentissa_in   = f;
    grs_in        = g;
    zero_in       = z;
    round_mode_in = m;
    valid_in      = 1'b1;
    accepted      = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 64'(accepted), 64'd1);
    else exp_q.push_back(expected);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    valid_in   = 1'b0;
    rand_ready = 1'b0;
    ready_in   = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic latency_check(input logic [7:0] e, input logic [22:0] f, input logic [31:0] w);
    send(1'b0, e, f, 3'b000, 1'b0, 2'd0, {2'b00, w});
    chk("lat_after_accept", 64'(valid_out), 64'd0);
    cycle();
    chk("lat_two_cycles", 64'(valid_out), 64'd1);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; sign_in = 1'b0;
    exponent_in = '0; mentissa_in = '0; grs_in = '0; zero_in = 1'b0; round_mode_in = 2'd0;
    repeat (3) @(negedge clk);
    cur_tag = "reset";
    chk("valid_out", 64'(valid_out), 64'd0);
    chk("word", 64'(floating_round_out), 64'd0);
    chk("overflow", 64'(overflow_out), 64'd0);
    chk("inexact", 64'(inexact_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_out", 64'(ready_out), 64'd1);

    cur_tag = "one";
    latency_check(8'd127, 23'd0, 32'h3F80_0000);

    cur_tag = "rne_ties";
    send(1'b0, 8'd127, 23'h000001, 3'b100, 1'b0, 2'd0, {2'b01, 32'h3F80_0002});
    send(1'b0, 8'd127, 23'h000002, 3'b100, 1'b0, 2'd0, {2'b01, 32'h3F80_0002});
    send(1'b1, 8'd127, 23'h000002, 3'b101, 1'b0, 2'd0, {2'b01, 32'hBF80_0003});
    drain();

    cur_tag = "carry_nan";
    send(1'b0, 8'd127, 23'h7FFFFF, 3'b110, 1'b0, 2'd0, {2'b01, 32'h4000_0000});
    send(1'b0, 8'hFF, 23'h400000, 3'b111, 1'b0, 2'd0, {2'b00, QNAN_DEFAULT});
    send(1'b1, 8'd200, 23'h123456, 3'b111, 1'b1, 2'd0, {2'b00, 32'h8000_0000});
    send(1'b0, 8'd0, 23'h7FFFFF, 3'b100, 1'b0, 2'd0, {2'b01, 32'h0080_0000});
    drain();

    cur_tag = "overflow";
    send(1'b0, 8'd254, 23'h7FFFFF, 3'b111, 1'b0, 2'd0, {2'b11, 32'h7F80_0000});
    send(1'b0, 8'd254, 23'h7FFFFF, 3'b011, 1'b0, 2'd0, {2'b01, 32'h7F7F_FFFF});
`ifdef FPU_ROUND_MODE_EN
    send(1'b0, 8'd254, 23'h7FFFFF, 3'b111, 1'b0, 2'd1, {2'b11, 32'h7F7F_FFFF});
    send(1'b1, 8'd254, 23'h7FFFFF, 3'b001, 1'b0, 2'd2, {2'b11, 32'hFF7F_FFFF});
    send(1'b1, 8'd254, 23'h7FFFFF, 3'b001, 1'b0, 2'd3, {2'b11, 32'hFF80_0000});
`endif
    drain();

    cur_tag = "backpressure";
    for (int i = 0; i < 2; i++)
      send(1'b0, 8'(100 + i), 23'(i * 3), 3'b000, 1'b0, 2'd0,
           {2'b00, 1'b0, 8'(100 + i), 23'(i * 3)});
    ready_in = 1'b0;
    sign_in = 1'b0; exponent_in = 8'd102; mentissa_in = 23'd6; grs_in = 3'b000; zero_in = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ready_out_full", 64'(ready_out), 64'd0);
      cycle();
    end
    ready_in = 1'b1;
    for (int i = 2; i < 6; i++)
      send(1'b0, 8'(100 + i), 23'(i * 3), 3'b000, 1'b0, 2'd0,
           {2'b00, 1'b0, 8'(100 + i), 23'(i * 3)});
    drain();

    cur_tag = "reset_mid";
    send(1'b0, 8'd127, 23'd0, 3'b000, 1'b0, 2'd0, {2'b00, 32'h3F80_0000});
    ready_in = 1'b0;
    send(1'b0, 8'd128, 23'd1, 3'b000, 1'b0, 2'd0, {2'b00, 32'h4000_0001});
    chk("full_before_rst", 64'(valid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("valid_out_cleared", 64'(valid_out), 64'd0);
    chk("word_cleared", 64'(floating_round_out), 64'd0);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    #1;
    chk("ready_after_rst", 64'(ready_out), 64'd1);
    @(negedge clk);
    latency_check(8'd128, 23'h490FDB, 32'h4049_0FDB);

    cur_tag = "random";
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      logic [2:0]  g;
      logic        z;
      logic [1:0]  m;
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(0, 255));
      f = 23'($urandom);
      g = 3'($urandom_range(0, 7));
      z = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        e = 8'd254;
        f = 23'h7FFFFF;
      end
      if ($urandom_range(0, 5) == 0) f = 23'h7FFFFF;
`ifdef FPU_ROUND_MODE_EN
      m = 2'($urandom_range(0, 3));
`else
      m = 2'd0;
`endif
      send(s, e, f, g, z, m, ref_model(s, e, f, g, z, m));
    end
    drain();

    cur_tag = "final";
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/addition_round_stage.md
Name: addition_round_stage

Overview:
- Stage 5 of the single-precision floating-point add/sub datapath, directly downstream of the exponent/mantissa normalizer.
- Takes the normalized sign, exponent and fraction plus guard/round/sticky bits, rounds, renormalizes on carry-out, saturates to infinity on overflow, and packs the IEEE-754 word.
- Two-stage registered pipeline with valid/ready handshake on both sides, so the combinational front end can be registered and backpressured.

Parameters:
DATA_WIDTH, 32, packed output width
MENT_WIDTH, 23, stored fraction width (hidden bit implicit)
EXPO_WIDTH, 8, biased exponent width
GRS_WIDTH, 3, guard/round/sticky width; bit 2 = G, bit 1 = R, bit 0 = S

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
valid_in  input  1  upstream data valid
ready_out  output  1  block accepts data this cycle
sign_in  input  1  result sign
exponent_in  input  EXPO_WIDTH  normalized biased exponent
mentissa_in  input  MENT_WIDTH  normalized fraction
grs_in  input  GRS_WIDTH  guard/round/sticky bits
zero_in  input  1  result is exactly zero
valid_out  output  1  output word valid
ready_in  input  1  downstream accepts
floating_round_out  output  DATA_WIDTH  {sign, exponent, fraction}
overflow_out  output  1  result saturated to infinity
inexact_out  output  1  any GRS bit was set on a finite, non-zero result

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - Clears both stage valids; all data registers go to 0.
  - valid_out=0, floating_round_out=0, overflow_out=0, inexact_out=0.
  - In-flight data is discarded.
- Handshake:
  - Transfer occurs on valid_in & ready_out; output transfers on valid_out & ready_in.
  - adv2 = !v2 | ready_in; adv1 = !v1 | adv2; ready_out = adv1 (combinational, no input-to-output path on data).
  - Throughput is 1 word/cycle; latency is exactly 2 cycles when unstalled.
  - While valid_out & !ready_in, all outputs are held stable.
  - No loss, duplication or reordering.
- Stage 1 (round decision):
  - Default mode is round-to-nearest-even: inc = G & (R | S | frac[0]).
  - Register {sign, exp, frac + inc (MENT_WIDTH+1 bits), special flags, inexact}.
- Stage 2 (renormalize and pack):
  - If the increment carries out: fraction = 0, exponent = exponent + 1.
  - If the resulting exponent equals all ones: output ±infinity (exponent all ones, fraction 0), overflow_out=1.
- Special cases:
  - exponent_in all ones (Inf/NaN): passed through unchanged; no rounding, overflow_out=0, inexact_out=0.
  - zero_in=1: output {sign_in, 0, 0}; grs_in is ignored.
  - exponent_in=0 with zero_in=0 (denormal) is rounded as a normal value with exponent 0; a carry-out yields exponent 1.
- Flags travel aligned with their data word.

Optional Feature:
- Macro: FPU_ROUND_MODE_EN.
- Defined:
  - Adds input round_mode_in [1:0], sampled with the data.
  - Modes: 00 RNE, 01 RTZ (inc=0), 10 round toward +inf (inc = !sign & |grs), 11 round toward -inf (inc = sign & |grs).
  - On overflow under RTZ, or under the directed mode pointing away from that sign, the output saturates to max finite (exponent all ones minus 1, fraction all ones) with overflow_out=1.
- Undefined:
  - No round_mode_in port; RNE only.

Decomposition:
- Shared package fpu_pkg:
  - Width localparams.
  - GRS bit indices.
  - round_mode_t enum (RNE/RTZ/RUP/RDN).
  - Constants EXP_ALL_ONES and QNAN_DEFAULT.
- One combinational sub-module, addition_round_decide:
  - Inputs: sign, lsb, grs, mode.
  - Outputs: inc, inexact.
  - Instantiated in stage 1.
- Pipeline registers and handshake stay in the top module.

Test Plan:
1. Exponent 127, fraction 0, grs=000, ready_in=1 -> 0x3F800000 two cycles later; inexact_out=0, overflow_out=0.
2. Tie cases under RNE:
   - Fraction 0x000001, grs=100 -> fraction 0x000002.
   - Fraction 0x000002, grs=100 -> fraction 0x000002.
   - inexact_out=1 for both.
3. Carry-out: sign 0, exponent 127, fraction 0x7FFFFF, grs=110 -> 0x40000000. NaN input 0x7FC00000 (grs=111) -> passes through unchanged with inexact_out=0.
4. Overflow: exponent 254, fraction 0x7FFFFF, grs=111 -> 0x7F800000 with overflow_out=1. With FPU_ROUND_MODE_EN and RTZ -> 0x7F7FFFFF with overflow_out=1.
5. Backpressure: stream 6 words, drop ready_in for 3 cycles mid-stream:
   - ready_out falls once both stages are full.
   - Output is held stable while stalled.
   - All 6 words emerge in order, exactly once.
6. Reset mid-operation: with both stages valid, pull rst_n_in low between clock edges -> valid_out=0 and floating_round_out=0 immediately. After release, ready_out=1 and the first new word appears 2 cycles after acceptance.
